// File: rtl/aux_in_evt_if.sv
// Auxiliary input event bus: raw inputs and controls from the fabric, filtered
// levels, sticky event flags and the interrupt back to it.
interface aux_in_evt_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] aux_in;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] evt_clr;
   logic [WIDTH-1:0] aux_i;
   logic [WIDTH-1:0] aux_evt;
   logic             aux_irq;

   modport master (
      output aux_in, rise_en, fall_en, irq_mask, evt_clr,
      input  aux_i, aux_evt, aux_irq
   );

   modport slave (
      input  aux_in, rise_en, fall_en, irq_mask, evt_clr,
      output aux_i, aux_evt, aux_irq
   );
endinterface

// File: rtl/aux_in_evt.sv
// Auxiliary input capture: N-stage synchroniser, optional debounce
// (AUX_IN_DEBOUNCE_EN), per-bit edge detection into sticky events and a masked interrupt.
module aux_in_evt #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 16
) (
   input logic          sys_clk,
   input logic          sys_rst,
   aux_in_evt_if.slave  bus
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("aux_in_evt: SYNC_STAGES must be in 2..4");
   end
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("aux_in_evt: DEB_CYCLES must be at least 1");
   end

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  sync_out;
   logic [WIDTH-1:0]                  aux_i_w;
   logic [WIDTH-1:0]                  prev_q;
   logic [WIDTH-1:0]                  evt_q;
   logic                              irq_q;
   logic [WIDTH-1:0]                  rise;
   logic [WIDTH-1:0]                  fall;
   logic [WIDTH-1:0]                  set_v;

   // NOTE: the synchroniser flops are reset as well, so aux_i reads 0 the cycle after reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.aux_in};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef AUX_IN_DEBOUNCE_EN
   localparam int             CW       = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CYCLES - 1);

   logic [WIDTH-1:0][CW-1:0] deb_cnt_q;
   logic [WIDTH-1:0]         filt_q;

   // A new level is accepted only after it has differed for DEB_CYCLES consecutive cycles.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         deb_cnt_q <= '0;
         filt_q    <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_out[i] == filt_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
               filt_q[i]    <= sync_out[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign aux_i_w = filt_q;
`else
   assign aux_i_w = sync_out;
`endif

   assign rise  = aux_i_w & ~prev_q;
   assign fall  = ~aux_i_w & prev_q;
   assign set_v = (rise & bus.rise_en) | (fall & bus.fall_en);

   // A fresh edge wins over a simultaneous clear so no event is ever lost.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         prev_q <= '0;
         evt_q  <= '0;
         irq_q  <= 1'b0;
      end else begin
         prev_q <= aux_i_w;
         evt_q  <= set_v | (evt_q & ~bus.evt_clr);
         irq_q  <= |(evt_q & bus.irq_mask);
      end
   end

   assign bus.aux_i   = aux_i_w;
   assign bus.aux_evt = evt_q;
   assign bus.aux_irq = irq_q;

endmodule

// File: tb/tb_aux_in_evt.sv
// Directed bench for aux_in_evt with SYNC_STAGES=3 (DEB_CYCLES=4 when AUX_IN_DEBOUNCE_EN is defined).
module tb_aux_in_evt;

   localparam int SYNC = 3;
   localparam int DEB  = 4;
`ifdef AUX_IN_DEBOUNCE_EN
   localparam int LAT = SYNC + DEB;
`else
   localparam int LAT = SYNC;
`endif

   logic sys_clk = 1'b0;
   logic sys_rst;
   int   checks = 0;
   int   errors = 0;

   always #5 sys_clk = ~sys_clk;

   aux_in_evt_if #(.WIDTH(32)) bus ();

   aux_in_evt #(
      .WIDTH       (32),
      .SYNC_STAGES (SYNC),
      .DEB_CYCLES  (DEB)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus.slave)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_all();
      bus.evt_clr = 32'hFFFF_FFFF;
      tick();
      bus.evt_clr = 32'h0;
   endtask

   task automatic test_reset();
      sys_rst      = 1'b1;
      bus.aux_in   = 32'hFFFF_FFFF;
      bus.rise_en  = 32'hFFFF_FFFF;
      bus.fall_en  = 32'h0;
      bus.irq_mask = 32'h0;
      bus.evt_clr  = 32'h0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (bus.aux_i !== 32'h0) begin errors++; $display("FAIL rst_aux_i: got %h want %h", bus.aux_i, 32'h0); end
         checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL rst_aux_evt: got %h want %h", bus.aux_evt, 32'h0); end
         checks++; if (bus.aux_irq !== 1'b0) begin errors++; $display("FAIL rst_aux_irq: got %b want 0", bus.aux_irq); end
      end
      sys_rst = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         if (k < LAT) begin
            checks++; if (bus.aux_i !== 32'h0) begin errors++; $display("FAIL post_rst_aux_i k=%0d: got %h want %h", k, bus.aux_i, 32'h0); end
            checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL post_rst_evt k=%0d: got %h want %h", k, bus.aux_evt, 32'h0); end
         end else if (k == LAT) begin
            checks++; if (bus.aux_i !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_rst_aux_i_high: got %h want %h", bus.aux_i, 32'hFFFF_FFFF); end
            checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL post_rst_evt_early: got %h want %h", bus.aux_evt, 32'h0); end
         end else begin
            checks++; if (bus.aux_evt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_rst_evt_set: got %h want %h", bus.aux_evt, 32'hFFFF_FFFF); end
         end
      end
      tick();
      checks++; if (bus.aux_irq !== 1'b0) begin errors++; $display("FAIL post_rst_irq_masked: got %b want 0", bus.aux_irq); end
      clear_all();
      checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL post_rst_clear: got %h want %h", bus.aux_evt, 32'h0); end
   endtask

   task automatic test_latency();
      bus.rise_en = 32'h0;
      bus.aux_in  = 32'h0;
      tick(LAT + 2);
      checks++; if (bus.aux_i !== 32'h0) begin errors++; $display("FAIL lat_idle_aux_i: got %h want %h", bus.aux_i, 32'h0); end
      checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL lat_idle_evt: got %h want %h", bus.aux_evt, 32'h0); end
      bus.rise_en  = 32'h20;
      bus.irq_mask = 32'h20;
      bus.aux_in   = 32'h20;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick();
         if (k < LAT) begin
            checks++; if (bus.aux_i !== 32'h0) begin errors++; $display("FAIL lat_aux_i_early k=%0d: got %h want %h", k, bus.aux_i, 32'h0); end
         end else if (k == LAT) begin
            checks++; if (bus.aux_i !== 32'h20) begin errors++; $display("FAIL lat_aux_i: got %h want %h", bus.aux_i, 32'h20); end
            checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL lat_evt_early: got %h want %h", bus.aux_evt, 32'h0); end
         end else if (k == LAT + 1) begin
            checks++; if (bus.aux_evt !== 32'h20) begin errors++; $display("FAIL lat_evt: got %h want %h", bus.aux_evt, 32'h20); end
            checks++; if (bus.aux_irq !== 1'b0) begin errors++; $display("FAIL lat_irq_early: got %b want 0", bus.aux_irq); end
         end else begin
            checks++; if (bus.aux_irq !== 1'b1) begin errors++; $display("FAIL lat_irq: got %b want 1", bus.aux_irq); end
         end
      end
      bus.irq_mask = 32'h0;
      clear_all();
   endtask

   task automatic test_edge_select();
      bus.rise_en = 32'h0;
      bus.fall_en = 32'h1;
      bus.aux_in  = 32'h21;
      tick(10);
      checks++; if (bus.aux_i !== 32'h21) begin errors++; $display("FAIL edge_rise_level: got %h want %h", bus.aux_i, 32'h21); end
      checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL edge_rise_ignored: got %h want %h", bus.aux_evt, 32'h0); end
      bus.aux_in = 32'h20;
      tick(LAT);
      checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL edge_fall_early: got %h want %h", bus.aux_evt, 32'h0); end
      tick();
      checks++; if (bus.aux_evt !== 32'h1) begin errors++; $display("FAIL edge_fall_set: got %h want %h", bus.aux_evt, 32'h1); end
      bus.fall_en = 32'h0;
      tick(5);
      checks++; if (bus.aux_evt !== 32'h1) begin errors++; $display("FAIL edge_sticky: got %h want %h", bus.aux_evt, 32'h1); end
      clear_all();
   endtask

   task automatic test_clear_collision();
      bus.rise_en  = 32'h4;
      bus.irq_mask = 32'h4;
      bus.aux_in   = 32'h24;
      tick(LAT + 1);
      checks++; if (bus.aux_evt !== 32'h4) begin errors++; $display("FAIL coll_setup: got %h want %h", bus.aux_evt, 32'h4); end
      bus.aux_in = 32'h20;
      tick(LAT + 2);
      checks++; if (bus.aux_evt !== 32'h4) begin errors++; $display("FAIL coll_hold: got %h want %h", bus.aux_evt, 32'h4); end
      bus.aux_in = 32'h24;
      tick(LAT);
      checks++; if (bus.aux_i !== 32'h24) begin errors++; $display("FAIL coll_rise_level: got %h want %h", bus.aux_i, 32'h24); end
      bus.evt_clr = 32'h4;
      tick();
      bus.evt_clr = 32'h0;
      checks++; if (bus.aux_evt !== 32'h4) begin errors++; $display("FAIL coll_set_wins: got %h want %h", bus.aux_evt, 32'h4); end
      tick();
      bus.evt_clr = 32'h4;
      tick();
      bus.evt_clr = 32'h0;
      checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL coll_clear: got %h want %h", bus.aux_evt, 32'h0); end
      checks++; if (bus.aux_irq !== 1'b1) begin errors++; $display("FAIL coll_irq_trail: got %b want 1", bus.aux_irq); end
      tick();
      checks++; if (bus.aux_irq !== 1'b0) begin errors++; $display("FAIL coll_irq_drop: got %b want 0", bus.aux_irq); end
      bus.irq_mask = 32'h0;
   endtask

   task automatic test_mask();
      bus.rise_en  = 32'h10;
      bus.fall_en  = 32'h0;
      bus.irq_mask = 32'h0;
      bus.aux_in   = 32'h34;
      tick(LAT + 1);
      checks++; if (bus.aux_evt !== 32'h10) begin errors++; $display("FAIL mask_evt: got %h want %h", bus.aux_evt, 32'h10); end
      tick(3);
      checks++; if (bus.aux_irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b want 0", bus.aux_irq); end
      bus.irq_mask = 32'h10;
      tick();
      checks++; if (bus.aux_irq !== 1'b1) begin errors++; $display("FAIL mask_irq_on: got %b want 1", bus.aux_irq); end
      bus.irq_mask = 32'h0;
      tick();
      checks++; if (bus.aux_irq !== 1'b0) begin errors++; $display("FAIL mask_irq_remask: got %b want 0", bus.aux_irq); end
      clear_all();
   endtask

   task automatic test_reset_mid();
      bus.rise_en  = 32'hFFFF_FFFF;
      bus.irq_mask = 32'hFFFF_FFFF;
      bus.aux_in   = 32'h35;
      tick(LAT + 1);
      checks++; if (bus.aux_evt !== 32'h1) begin errors++; $display("FAIL mid_evt_pending: got %h want %h", bus.aux_evt, 32'h1); end
      sys_rst = 1'b1;
      tick();
      checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL mid_rst_evt: got %h want %h", bus.aux_evt, 32'h0); end
      checks++; if (bus.aux_irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b want 0", bus.aux_irq); end
      bus.rise_en = 32'h0;
      sys_rst     = 1'b0;
      tick(LAT + 3);
      checks++; if (bus.aux_i !== 32'h35) begin errors++; $display("FAIL mid_after_aux_i: got %h want %h", bus.aux_i, 32'h35); end
      checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL mid_after_evt: got %h want %h", bus.aux_evt, 32'h0); end
      checks++; if (bus.aux_irq !== 1'b0) begin errors++; $display("FAIL mid_after_irq: got %b want 0", bus.aux_irq); end
      bus.irq_mask = 32'h0;
   endtask

`ifdef AUX_IN_DEBOUNCE_EN
   task automatic test_debounce();
      bus.rise_en = 32'h100;
      bus.aux_in  = 32'h135;
      tick(3);
      bus.aux_in = 32'h35;
      tick(12);
      checks++; if (bus.aux_i !== 32'h35) begin errors++; $display("FAIL deb_glitch_aux_i: got %h want %h", bus.aux_i, 32'h35); end
      checks++; if (bus.aux_evt !== 32'h0) begin errors++; $display("FAIL deb_glitch_evt: got %h want %h", bus.aux_evt, 32'h0); end
      bus.aux_in = 32'h135;
      tick(LAT - 1);
      checks++; if (bus.aux_i !== 32'h35) begin errors++; $display("FAIL deb_stable_early: got %h want %h", bus.aux_i, 32'h35); end
      tick();
      checks++; if (bus.aux_i !== 32'h135) begin errors++; $display("FAIL deb_stable_accept: got %h want %h", bus.aux_i, 32'h135); end
      tick();
      checks++; if (bus.aux_evt !== 32'h100) begin errors++; $display("FAIL deb_stable_evt: got %h want %h", bus.aux_evt, 32'h100); end
      clear_all();
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_edge_select();
      test_clear_collision();
      test_mask();
      test_reset_mid();
`ifdef AUX_IN_DEBOUNCE_EN
      test_debounce();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
